// File: rtl/modo_jogo_controle_if.sv
// Control bundle between the game controller and its datapath.
// The controller uses the master view; the datapath or player side uses the slave view.
interface modo_jogo_controle_if #(
    parameter int ADDR_W = 4
);
    logic              iniciar;
    logic              fimTF;
    logic              fimTempo;
    logic              tempo_mostra_ok;
    logic              nota_feita;
    logic              nota_correta;
    logic              tempo_correto;
    logic              tentar_dnv;
    logic              tentar_dnv_rep;
    logic [1:0]        modo;

    logic [ADDR_W-1:0] endereco;
    logic [ADDR_W-1:0] rodada;
    logic [2:0]        vidas;
    logic              zeraTF;
    logic              contaTF;
    logic              zeraTempo;
    logic              contaTempo;
    logic              zeraMetro;
    logic              contaMetro;
    logic              zeraR;
    logic              registraR;
    logic              toca;
    logic              ativa_leds;
    logic              leds_mem;
    logic              vez_jogador;
    logic              ganhou;
    logic              perdeu;
    logic [4:0]        db_estado;

    modport master (
        input  iniciar, fimTF, fimTempo, tempo_mostra_ok, nota_feita,
               nota_correta, tempo_correto, tentar_dnv, tentar_dnv_rep, modo,
        output endereco, rodada, vidas, zeraTF, contaTF, zeraTempo, contaTempo,
               zeraMetro, contaMetro, zeraR, registraR, toca, ativa_leds,
               leds_mem, vez_jogador, ganhou, perdeu, db_estado
    );

    modport slave (
        output iniciar, fimTF, fimTempo, tempo_mostra_ok, nota_feita,
               nota_correta, tempo_correto, tentar_dnv, tentar_dnv_rep, modo,
        input  endereco, rodada, vidas, zeraTF, contaTF, zeraTempo, contaTempo,
               zeraMetro, contaMetro, zeraR, registraR, toca, ativa_leds,
               leds_mem, vez_jogador, ganhou, perdeu, db_estado
    );
endinterface

// File: rtl/modo_jogo_controle.sv
// Moore controller for the music memory game: progressive, full-song and free-play modes,
// with a lives counter, round/note address counters and registered state-decoded outputs.
module modo_jogo_controle #(
    parameter int ADDR_W = 4,
    parameter int ULTIMA = 15,
    parameter int VIDAS  = 3
) (
    input logic                   clock,
    input logic                   reset,
    modo_jogo_controle_if.master  bus
);

    typedef enum logic [4:0] {
        INICIAL        = 5'h00,
        INICIALIZA     = 5'h01,
        INICIO_RODADA  = 5'h02,
        MOSTRA         = 5'h03,
        ESPERA_MOSTRA  = 5'h04,
        APAGA_MOSTRA   = 5'h05,
        INICIO_NOTA    = 5'h06,
        ESPERA_NOTA    = 5'h07,
        TOCA_NOTA      = 5'h08,
        COMPARA        = 5'h09,
        PROXIMA_NOTA   = 5'h0A,
        PROXIMA_RODADA = 5'h0B,
        ERROU          = 5'h0C,
        AGUARDA        = 5'h0D,
        GANHOU         = 5'h0E,
        DERROTA        = 5'h0F
    } state_t;

    typedef struct packed {
        logic zera_tf;
        logic conta_tf;
        logic zera_tempo;
        logic conta_tempo;
        logic zera_metro;
        logic conta_metro;
        logic zera_r;
        logic registra_r;
        logic toca;
        logic ativa_leds;
        logic leds_mem;
        logic vez_jogador;
        logic ganhou;
        logic perdeu;
    } ctrl_t;

    localparam logic [ADDR_W-1:0] LAST       = ADDR_W'(ULTIMA);
    localparam logic [ADDR_W-1:0] ONE        = ADDR_W'(1);
    localparam logic [2:0]        LIVES      = 3'(VIDAS);
    localparam logic [1:0]        MODO_PROG  = 2'd0;
    localparam logic [1:0]        MODO_FULL  = 2'd1;
    localparam logic [1:0]        MODO_LIVRE = 2'd2;

    state_t            state_q;
    state_t            state_d;
    ctrl_t             ctrl_q;
    logic [ADDR_W-1:0] endereco_q;
    logic [ADDR_W-1:0] rodada_q;
    logic [2:0]        vidas_q;
    logic [1:0]        modo_reg;
    logic [1:0]        modo_eff;

    // Mode 3 is not a game of its own; it plays exactly like progressive mode.
    assign modo_eff = (bus.modo == 2'd3) ? MODO_PROG : bus.modo;

    function automatic ctrl_t decode(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            INICIAL:        c.zera_r = 1'b1;
            INICIALIZA:     begin c.zera_tf = 1'b1; c.zera_tempo = 1'b1; c.zera_metro = 1'b1; end
            INICIO_RODADA:  c.conta_tf = 1'b1;
            MOSTRA:         begin c.zera_tf = 1'b1; c.zera_metro = 1'b1; end
            ESPERA_MOSTRA:  begin
                c.conta_metro = 1'b1; c.toca = 1'b1; c.ativa_leds = 1'b1; c.leds_mem = 1'b1;
            end
            APAGA_MOSTRA:   c.conta_tf = 1'b1;
            INICIO_NOTA:    begin c.zera_tf = 1'b1; c.zera_tempo = 1'b1; c.zera_metro = 1'b1; end
            ESPERA_NOTA:    begin c.conta_tempo = 1'b1; c.vez_jogador = 1'b1; end
            TOCA_NOTA:      begin
                c.registra_r = 1'b1; c.conta_metro = 1'b1; c.toca = 1'b1; c.ativa_leds = 1'b1;
            end
            PROXIMA_NOTA:   begin c.zera_tempo = 1'b1; c.zera_metro = 1'b1; end
            ERROU:          begin c.zera_tempo = 1'b1; c.zera_metro = 1'b1; end
            AGUARDA:        c.perdeu = 1'b1;
            GANHOU:         c.ganhou = 1'b1;
            DERROTA:        c.perdeu = 1'b1;
            default:        c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        state_d = state_q;
        case (state_q)
            INICIAL:        if (bus.iniciar) state_d = INICIALIZA;
            INICIALIZA:     state_d = (modo_eff == MODO_LIVRE) ? INICIO_NOTA : INICIO_RODADA;
            INICIO_RODADA:  if (bus.fimTF) state_d = MOSTRA;
            MOSTRA:         state_d = ESPERA_MOSTRA;
            ESPERA_MOSTRA:  if (bus.tempo_mostra_ok)
                                state_d = (endereco_q == rodada_q) ? INICIO_NOTA : APAGA_MOSTRA;
            APAGA_MOSTRA:   if (bus.fimTF) state_d = MOSTRA;
            INICIO_NOTA:    state_d = ESPERA_NOTA;
            ESPERA_NOTA: begin
                // Free play has no timeout; iniciar is the only way out of it.
                if (modo_reg == MODO_LIVRE) begin
                    if (bus.iniciar)         state_d = INICIALIZA;
                    else if (bus.nota_feita) state_d = TOCA_NOTA;
                end else begin
                    if (bus.fimTempo)        state_d = ERROU;
                    else if (bus.nota_feita) state_d = TOCA_NOTA;
                end
            end
            TOCA_NOTA:      if (!bus.nota_feita)
                                state_d = (modo_reg == MODO_LIVRE) ? ESPERA_NOTA : COMPARA;
            COMPARA: begin
                if (!bus.nota_correta || !bus.tempo_correto) state_d = ERROU;
                else if (endereco_q == rodada_q)
                    state_d = (rodada_q == LAST) ? GANHOU : PROXIMA_RODADA;
                else                                         state_d = PROXIMA_NOTA;
            end
            PROXIMA_NOTA:   state_d = ESPERA_NOTA;
            PROXIMA_RODADA: state_d = INICIO_RODADA;
            ERROU:          state_d = (vidas_q <= 3'd1) ? DERROTA : AGUARDA;
            AGUARDA: begin
                if (bus.tentar_dnv_rep)  state_d = INICIO_RODADA;
                else if (bus.tentar_dnv) state_d = INICIO_NOTA;
            end
            GANHOU, DERROTA: if (bus.iniciar) state_d = INICIALIZA;
            default:        state_d = INICIAL;
        endcase
    end

    // Outputs are registered from the next state so they always match the current state code.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= INICIAL;
            ctrl_q     <= decode(INICIAL);
            endereco_q <= '0;
            rodada_q   <= '0;
            vidas_q    <= LIVES;
            modo_reg   <= MODO_PROG;
        end else begin
            state_q <= state_d;
            ctrl_q  <= decode(state_d);
            case (state_q)
                INICIALIZA: begin
                    modo_reg   <= modo_eff;
                    endereco_q <= '0;
                    vidas_q    <= LIVES;
                    rodada_q   <= (modo_eff == MODO_FULL) ? LAST : '0;
                end
                INICIO_RODADA, INICIO_NOTA: endereco_q <= '0;
                APAGA_MOSTRA:   if (bus.fimTF && endereco_q != LAST) endereco_q <= endereco_q + ONE;
                PROXIMA_NOTA:   if (endereco_q != LAST) endereco_q <= endereco_q + ONE;
                PROXIMA_RODADA: if (rodada_q != LAST) rodada_q <= rodada_q + ONE;
                ERROU:          if (vidas_q != 3'd0) vidas_q <= vidas_q - 3'd1;
                default: ;
            endcase
        end
    end

    assign bus.endereco    = endereco_q;
    assign bus.rodada      = rodada_q;
    assign bus.vidas       = vidas_q;
    assign bus.db_estado   = state_q;
    assign bus.zeraTF      = ctrl_q.zera_tf;
    assign bus.contaTF     = ctrl_q.conta_tf;
    assign bus.zeraTempo   = ctrl_q.zera_tempo;
    assign bus.contaTempo  = ctrl_q.conta_tempo;
    assign bus.zeraMetro   = ctrl_q.zera_metro;
    assign bus.contaMetro  = ctrl_q.conta_metro;
    assign bus.zeraR       = ctrl_q.zera_r;
    assign bus.registraR   = ctrl_q.registra_r;
    assign bus.toca        = ctrl_q.toca;
    assign bus.ativa_leds  = ctrl_q.ativa_leds;
    assign bus.leds_mem    = ctrl_q.leds_mem;
    assign bus.vez_jogador = ctrl_q.vez_jogador;
    assign bus.ganhou      = ctrl_q.ganhou;
    assign bus.perdeu      = ctrl_q.perdeu;

endmodule

// File: tb/tb_modo_jogo_controle.sv
// Self-checking bench for modo_jogo_controle: directed scenarios plus randomized games
// scored against a game-level model of rounds, lives and shown notes.
module tb_modo_jogo_controle;

    localparam int ADDR_W = 4;
    localparam int ULTIMA = 2;
    localparam int VIDAS  = 3;
    localparam int BUDGET = 300;

    localparam logic [4:0] S_INICIAL        = 5'h00;
    localparam logic [4:0] S_INICIALIZA     = 5'h01;
    localparam logic [4:0] S_INICIO_RODADA  = 5'h02;
    localparam logic [4:0] S_ESPERA_MOSTRA  = 5'h04;
    localparam logic [4:0] S_INICIO_NOTA    = 5'h06;
    localparam logic [4:0] S_ESPERA_NOTA    = 5'h07;
    localparam logic [4:0] S_TOCA_NOTA      = 5'h08;
    localparam logic [4:0] S_PROXIMA_NOTA   = 5'h0A;
    localparam logic [4:0] S_PROXIMA_RODADA = 5'h0B;
    localparam logic [4:0] S_ERROU          = 5'h0C;
    localparam logic [4:0] S_AGUARDA        = 5'h0D;
    localparam logic [4:0] S_GANHOU         = 5'h0E;
    localparam logic [4:0] S_DERROTA        = 5'h0F;

    logic clock;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   auto_dp = 1'b0;
    bit   hold_show = 1'b0;
    int   shown[$];
    logic prev_leds = 1'b0;

    modo_jogo_controle_if #(.ADDR_W(ADDR_W)) bus();

    modo_jogo_controle #(.ADDR_W(ADDR_W), .ULTIMA(ULTIMA), .VIDAS(VIDAS)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Timer datapath stand-in: fimTF and tempo_mostra_ok arrive after random delays.
    initial begin
        bus.fimTF = 1'b0;
        bus.tempo_mostra_ok = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            bus.fimTF           = auto_dp && ($urandom_range(0, 2) != 0);
            bus.tempo_mostra_ok = auto_dp && !hold_show && ($urandom_range(0, 2) != 0);
        end
    end

    // Records the address of every note lit from memory.
    initial begin
        forever begin
            @(posedge clock);
            #2;
            if (bus.leds_mem === 1'b1 && prev_leds !== 1'b1) shown.push_back(int'(bus.endereco));
            prev_leds = bus.leds_mem;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [13:0] spec_outputs(input logic [4:0] s);
        logic [13:0] v;
        v[13] = (s == 5'h00);
        v[12] = (s == 5'h01) || (s == 5'h03) || (s == 5'h06);
        v[11] = (s == 5'h02) || (s == 5'h05);
        v[10] = (s == 5'h01) || (s == 5'h06) || (s == 5'h0A) || (s == 5'h0C);
        v[9]  = (s == 5'h07);
        v[8]  = (s == 5'h07);
        v[7]  = (s == 5'h08);
        v[6]  = (s == 5'h01) || (s == 5'h03) || (s == 5'h06) || (s == 5'h0A) || (s == 5'h0C);
        v[5]  = (s == 5'h04) || (s == 5'h08);
        v[4]  = (s == 5'h04) || (s == 5'h08);
        v[3]  = (s == 5'h04) || (s == 5'h08);
        v[2]  = (s == 5'h04);
        v[1]  = (s == 5'h0E);
        v[0]  = (s == 5'h0D) || (s == 5'h0F);
        return v;
    endfunction

    function automatic logic [13:0] dut_outputs();
        return {bus.zeraR, bus.zeraTF, bus.contaTF, bus.zeraTempo, bus.contaTempo,
                bus.vez_jogador, bus.registraR, bus.zeraMetro, bus.contaMetro, bus.toca,
                bus.ativa_leds, bus.leds_mem, bus.ganhou, bus.perdeu};
    endfunction

    function automatic bit shown_is_prefix(input int last);
        if (shown.size() != last + 1) return 1'b0;
        for (int i = 0; i <= last; i++) if (shown[i] != i) return 1'b0;
        return 1'b1;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_state(input logic [4:0] code, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            if (bus.db_estado === code) begin
                ok = 1'b1;
                return;
            end
            step();
        end
        ok = (bus.db_estado === code);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        bus.iniciar = 1'b0;
        bus.fimTempo = 1'b0;
        bus.nota_feita = 1'b0;
        bus.nota_correta = 1'b0;
        bus.tempo_correto = 1'b0;
        bus.tentar_dnv = 1'b0;
        bus.tentar_dnv_rep = 1'b0;
        bus.modo = 2'd0;
        hold_show = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        shown.delete();
    endtask

    task automatic start_game(input logic [1:0] mode);
        bus.modo = mode;
        bus.iniciar = 1'b1;
        step();
        bus.iniciar = 1'b0;
        shown.delete();
    endtask

    task automatic play_note(input bit good_note, input bit good_time);
        int hold;
        hold = $urandom_range(1, 3);
        bus.nota_correta = good_note;
        bus.tempo_correto = good_time;
        bus.nota_feita = 1'b1;
        repeat (hold) step();
        bus.nota_feita = 1'b0;
        step();
        step();
    endtask

    task automatic pulse_retry(input bit replay);
        if (replay) bus.tentar_dnv_rep = 1'b1;
        else        bus.tentar_dnv = 1'b1;
        step();
        bus.tentar_dnv_rep = 1'b0;
        bus.tentar_dnv = 1'b0;
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        reset = 1'b0;
        step();
        step();
        n_cmp++;
        if (bus.db_estado !== S_INICIAL) begin
            n_bad++; $display("FAIL reset_state: got %h expected %h", bus.db_estado, S_INICIAL);
        end
        n_cmp++;
        if (dut_outputs() !== spec_outputs(S_INICIAL)) begin
            n_bad++; $display("FAIL reset_outputs: got %b expected %b", dut_outputs(), spec_outputs(S_INICIAL));
        end
        n_cmp++;
        if (bus.vidas !== 3'(VIDAS)) begin
            n_bad++; $display("FAIL reset_vidas: got %0d expected %0d", bus.vidas, VIDAS);
        end
        n_cmp++;
        if (bus.endereco !== '0 || bus.rodada !== '0) begin
            n_bad++; $display("FAIL reset_counters: got endereco=%0d rodada=%0d expected 0/0", bus.endereco, bus.rodada);
        end
        reset = 1'b1;
        repeat (3) step();
        n_cmp++;
        if (bus.db_estado !== S_INICIAL) begin
            n_bad++; $display("FAIL idle_hold: got %h expected %h", bus.db_estado, S_INICIAL);
        end
    endtask

    task automatic test_progressive_win();
        bit ok;
        $display("[TB] test_progressive_win");
        do_reset();
        start_game(2'd0);
        for (int r = 0; r <= ULTIMA; r++) begin
            for (int i = 0; i <= r; i++) begin
                wait_state(S_ESPERA_NOTA, ok);
                n_cmp++;
                if (!ok) begin
                    n_bad++; $display("FAIL prog_wait_turn: got state %h expected %h", bus.db_estado, S_ESPERA_NOTA);
                    return;
                end
                if (i == 0) begin
                    n_cmp++;
                    if (!shown_is_prefix(r)) begin
                        n_bad++; $display("FAIL prog_shown_round%0d: got %0d notes expected notes 0..%0d", r, shown.size(), r);
                    end
                    shown.delete();
                end
                n_cmp++;
                if (int'(bus.endereco) != i || int'(bus.rodada) != r) begin
                    n_bad++; $display("FAIL prog_addr: got endereco=%0d rodada=%0d expected %0d/%0d", bus.endereco, bus.rodada, i, r);
                end
                play_note(1'b1, 1'b1);
            end
        end
        n_cmp++;
        if (bus.db_estado !== S_GANHOU || bus.ganhou !== 1'b1) begin
            n_bad++; $display("FAIL prog_win: got state %h ganhou=%b expected %h/1", bus.db_estado, bus.ganhou, S_GANHOU);
        end
        n_cmp++;
        if (int'(bus.endereco) != ULTIMA || int'(bus.rodada) != ULTIMA) begin
            n_bad++; $display("FAIL prog_win_addr: got %0d/%0d expected %0d/%0d", bus.endereco, bus.rodada, ULTIMA, ULTIMA);
        end
        repeat (4) step();
        n_cmp++;
        if (bus.db_estado !== S_GANHOU) begin
            n_bad++; $display("FAIL win_hold: got %h expected %h", bus.db_estado, S_GANHOU);
        end
    endtask

    task automatic test_full_song();
        bit ok;
        $display("[TB] test_full_song");
        start_game(2'd1);
        n_cmp++;
        if (bus.db_estado !== S_INICIALIZA) begin
            n_bad++; $display("FAIL full_restart: got %h expected %h", bus.db_estado, S_INICIALIZA);
        end
        step();
        n_cmp++;
        if (int'(bus.rodada) != ULTIMA || bus.db_estado !== S_INICIO_RODADA) begin
            n_bad++; $display("FAIL full_rodada: got rodada=%0d state %h expected %0d/%h", bus.rodada, bus.db_estado, ULTIMA, S_INICIO_RODADA);
        end
        for (int i = 0; i <= ULTIMA; i++) begin
            wait_state(S_ESPERA_NOTA, ok);
            n_cmp++;
            if (!ok) begin
                n_bad++; $display("FAIL full_wait_turn: got state %h expected %h", bus.db_estado, S_ESPERA_NOTA);
                return;
            end
            if (i == 0) begin
                n_cmp++;
                if (!shown_is_prefix(ULTIMA)) begin
                    n_bad++; $display("FAIL full_shown: got %0d notes expected %0d", shown.size(), ULTIMA + 1);
                end
            end
            play_note(1'b1, 1'b1);
        end
        n_cmp++;
        if (bus.ganhou !== 1'b1) begin
            n_bad++; $display("FAIL full_win: got ganhou=%b state %h expected 1", bus.ganhou, bus.db_estado);
        end
    endtask

    task automatic test_wrong_note();
        bit ok;
        $display("[TB] test_wrong_note");
        do_reset();
        start_game(2'd0);
        wait_state(S_ESPERA_NOTA, ok);
        play_note(1'b1, 1'b1);
        wait_state(S_ESPERA_NOTA, ok);
        play_note(1'b1, 1'b1);
        wait_state(S_ESPERA_NOTA, ok);
        n_cmp++;
        if (!ok || int'(bus.endereco) != 1) begin
            n_bad++; $display("FAIL wrong_setup: got state %h endereco=%0d expected %h/1", bus.db_estado, bus.endereco, S_ESPERA_NOTA);
            return;
        end
        play_note(1'b0, 1'b1);
        n_cmp++;
        if (bus.db_estado !== S_ERROU) begin
            n_bad++; $display("FAIL wrong_errou: got %h expected %h", bus.db_estado, S_ERROU);
        end
        step();
        n_cmp++;
        if (bus.db_estado !== S_AGUARDA || bus.vidas !== 3'd2 || bus.perdeu !== 1'b1) begin
            n_bad++; $display("FAIL wrong_aguarda: got state %h vidas=%0d perdeu=%b expected %h/2/1", bus.db_estado, bus.vidas, bus.perdeu, S_AGUARDA);
        end
        pulse_retry(1'b0);
        n_cmp++;
        if (bus.db_estado !== S_INICIO_NOTA) begin
            n_bad++; $display("FAIL retry_state: got %h expected %h", bus.db_estado, S_INICIO_NOTA);
        end
        step();
        n_cmp++;
        if (bus.db_estado !== S_ESPERA_NOTA || bus.endereco !== '0) begin
            n_bad++; $display("FAIL retry_addr: got state %h endereco=%0d expected %h/0", bus.db_estado, bus.endereco, S_ESPERA_NOTA);
        end
        play_note(1'b1, 1'b0);
        step();
        n_cmp++;
        if (bus.db_estado !== S_AGUARDA || bus.vidas !== 3'd1) begin
            n_bad++; $display("FAIL bad_timing: got state %h vidas=%0d expected %h/1", bus.db_estado, bus.vidas, S_AGUARDA);
        end
        shown.delete();
        pulse_retry(1'b1);
        n_cmp++;
        if (bus.db_estado !== S_INICIO_RODADA) begin
            n_bad++; $display("FAIL replay_state: got %h expected %h", bus.db_estado, S_INICIO_RODADA);
        end
        wait_state(S_ESPERA_NOTA, ok);
        n_cmp++;
        if (!ok || !shown_is_prefix(1) || bus.rodada !== 4'd1) begin
            n_bad++; $display("FAIL replay_shown: got %0d notes rodada=%0d expected 2/1", shown.size(), bus.rodada);
        end
    endtask

    task automatic test_timeouts();
        bit ok;
        int extra;
        $display("[TB] test_timeouts");
        do_reset();
        start_game(2'd0);
        for (int k = 0; k < VIDAS; k++) begin
            wait_state(S_ESPERA_NOTA, ok);
            n_cmp++;
            if (!ok) begin
                n_bad++; $display("FAIL timeout_wait: got %h expected %h", bus.db_estado, S_ESPERA_NOTA);
                return;
            end
            bus.fimTempo = 1'b1;
            step();
            bus.fimTempo = 1'b0;
            step();
            n_cmp++;
            if (int'(bus.vidas) != VIDAS - 1 - k) begin
                n_bad++; $display("FAIL timeout_vidas%0d: got %0d expected %0d", k, bus.vidas, VIDAS - 1 - k);
            end
            n_cmp++;
            if (bus.db_estado !== ((k == VIDAS - 1) ? S_DERROTA : S_AGUARDA)) begin
                n_bad++; $display("FAIL timeout_state%0d: got %h", k, bus.db_estado);
            end
            if (k != VIDAS - 1) pulse_retry(1'b0);
        end
        extra = $urandom_range(2, 5);
        for (int c = 0; c < extra; c++) begin
            n_cmp++;
            if (bus.perdeu !== 1'b1 || bus.db_estado !== S_DERROTA) begin
                n_bad++; $display("FAIL derrota_hold: got perdeu=%b state %h expected 1/%h", bus.perdeu, bus.db_estado, S_DERROTA);
            end
            step();
        end
        start_game(2'd0);
        n_cmp++;
        if (bus.db_estado !== S_INICIALIZA || bus.perdeu !== 1'b0) begin
            n_bad++; $display("FAIL derrota_exit: got state %h perdeu=%b expected %h/0", bus.db_estado, bus.perdeu, S_INICIALIZA);
        end
        step();
        n_cmp++;
        if (int'(bus.vidas) != VIDAS) begin
            n_bad++; $display("FAIL lives_refill: got %0d expected %0d", bus.vidas, VIDAS);
        end
    endtask

    task automatic test_free_play();
        int n;
        int cnt;
        $display("[TB] test_free_play");
        do_reset();
        start_game(2'd2);
        step();
        n_cmp++;
        if (bus.db_estado !== S_INICIO_NOTA) begin
            n_bad++; $display("FAIL free_entry: got %h expected %h", bus.db_estado, S_INICIO_NOTA);
        end
        step();
        bus.fimTempo = 1'b1;
        repeat ($urandom_range(2, 4)) step();
        n_cmp++;
        if (bus.db_estado !== S_ESPERA_NOTA || bus.vez_jogador !== 1'b1) begin
            n_bad++; $display("FAIL free_timeout_ignored: got state %h vez=%b expected %h/1", bus.db_estado, bus.vez_jogador, S_ESPERA_NOTA);
        end
        bus.fimTempo = 1'b0;
        for (int p = 0; p < 3; p++) begin
            n = $urandom_range(1, 4);
            cnt = 0;
            bus.nota_correta = 1'($urandom_range(0, 1));
            bus.nota_feita = 1'b1;
            repeat (n) begin
                step();
                if (bus.registraR === 1'b1) cnt++;
            end
            bus.nota_feita = 1'b0;
            step();
            if (bus.registraR === 1'b1) cnt++;
            n_cmp++;
            if (cnt != n || bus.db_estado !== S_ESPERA_NOTA) begin
                n_bad++; $display("FAIL free_registra%0d: got %0d cycles state %h expected %0d/%h", p, cnt, bus.db_estado, n, S_ESPERA_NOTA);
            end
        end
        bus.iniciar = 1'b1;
        step();
        bus.iniciar = 1'b0;
        n_cmp++;
        if (bus.db_estado !== S_INICIALIZA) begin
            n_bad++; $display("FAIL free_restart: got %h expected %h", bus.db_estado, S_INICIALIZA);
        end
    endtask

    task automatic test_output_decode();
        bit seen_error;
        bit done;
        $display("[TB] test_output_decode");
        do_reset();
        start_game(2'd1);
        seen_error = 1'b0;
        done = 1'b0;
        for (int c = 0; c < BUDGET && !done; c++) begin
            n_cmp++;
            if (dut_outputs() !== spec_outputs(bus.db_estado)) begin
                n_bad++; $display("FAIL decode_state%h: got %b expected %b", bus.db_estado, dut_outputs(), spec_outputs(bus.db_estado));
            end
            if (bus.db_estado === S_GANHOU) done = 1'b1;
            bus.tentar_dnv_rep = (bus.db_estado === S_AGUARDA);
            if (bus.db_estado === S_ERROU) seen_error = 1'b1;
            if (bus.db_estado === S_ESPERA_NOTA) begin
                bus.nota_feita = 1'b1;
                bus.nota_correta = seen_error;
                bus.tempo_correto = 1'b1;
            end
            if (bus.db_estado === S_TOCA_NOTA) bus.nota_feita = 1'b0;
            if (!done) step();
        end
        bus.tentar_dnv_rep = 1'b0;
        n_cmp++;
        if (!done || !seen_error) begin
            n_bad++; $display("FAIL decode_walk: got done=%b error_seen=%b expected 1/1", done, seen_error);
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        $display("[TB] test_async_reset");
        do_reset();
        start_game(2'd0);
        wait_state(S_ESPERA_NOTA, ok);
        bus.fimTempo = 1'b1;
        step();
        bus.fimTempo = 1'b0;
        step();
        pulse_retry(1'b0);
        wait_state(S_ESPERA_NOTA, ok);
        hold_show = 1'b1;
        play_note(1'b1, 1'b1);
        wait_state(S_ESPERA_MOSTRA, ok);
        n_cmp++;
        if (!ok || bus.vidas !== 3'd2 || bus.rodada !== 4'd1) begin
            n_bad++; $display("FAIL areset_setup: got state %h vidas=%0d rodada=%0d expected %h/2/1", bus.db_estado, bus.vidas, bus.rodada, S_ESPERA_MOSTRA);
        end
        #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if (bus.db_estado !== S_INICIAL || bus.zeraR !== 1'b1) begin
            n_bad++; $display("FAIL areset_state: got %h zeraR=%b expected %h/1", bus.db_estado, bus.zeraR, S_INICIAL);
        end
        n_cmp++;
        if (int'(bus.vidas) != VIDAS || bus.rodada !== '0 || bus.endereco !== '0) begin
            n_bad++; $display("FAIL areset_counters: got vidas=%0d rodada=%0d endereco=%0d expected %0d/0/0", bus.vidas, bus.rodada, bus.endereco, VIDAS);
        end
        hold_show = 1'b0;
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic test_random_games();
        bit ok;
        bit over;
        bit need_show;
        bit rep;
        int lives;
        int rnd;
        int act;
        int pick;
        logic [1:0] mode;
        $display("[TB] test_random_games");
        do_reset();
        for (int g = 0; g < 8; g++) begin
            pick = $urandom_range(0, 2);
            mode = (pick == 0) ? 2'd0 : (pick == 1) ? 2'd1 : 2'd3;
            start_game(mode);
            lives = VIDAS;
            rnd = (mode == 2'd1) ? ULTIMA : 0;
            need_show = 1'b1;
            over = 1'b0;
            while (!over) begin
                for (int idx = 0; idx <= rnd; idx++) begin
                    wait_state(S_ESPERA_NOTA, ok);
                    n_cmp++;
                    if (!ok) begin
                        n_bad++; $display("FAIL rand_wait: game %0d got %h expected %h", g, bus.db_estado, S_ESPERA_NOTA);
                        return;
                    end
                    if (idx == 0) begin
                        n_cmp++;
                        if (need_show ? !shown_is_prefix(rnd) : (shown.size() != 0)) begin
                            n_bad++; $display("FAIL rand_shown: game %0d got %0d notes expected %0d", g, shown.size(), need_show ? rnd + 1 : 0);
                        end
                        shown.delete();
                    end
                    n_cmp++;
                    if (int'(bus.endereco) != idx || int'(bus.rodada) != rnd) begin
                        n_bad++; $display("FAIL rand_addr: got %0d/%0d expected %0d/%0d", bus.endereco, bus.rodada, idx, rnd);
                    end
                    act = $urandom_range(0, 9);
                    if (act == 0) begin
                        bus.fimTempo = 1'b1;
                        step();
                        bus.fimTempo = 1'b0;
                    end else begin
                        play_note(act != 1, act != 2);
                    end
                    if (act <= 2) begin
                        lives--;
                        n_cmp++;
                        if (bus.db_estado !== S_ERROU) begin
                            n_bad++; $display("FAIL rand_errou: got %h expected %h", bus.db_estado, S_ERROU);
                        end
                        step();
                        n_cmp++;
                        if (int'(bus.vidas) != lives || bus.db_estado !== ((lives == 0) ? S_DERROTA : S_AGUARDA)) begin
                            n_bad++; $display("FAIL rand_lives: got vidas=%0d state %h expected %0d", bus.vidas, bus.db_estado, lives);
                        end
                        if (lives == 0) begin
                            over = 1'b1;
                        end else begin
                            rep = 1'($urandom_range(0, 1));
                            pulse_retry(rep);
                            need_show = rep;
                        end
                        break;
                    end else if (idx == rnd) begin
                        n_cmp++;
                        if (rnd == ULTIMA) begin
                            if (bus.db_estado !== S_GANHOU || bus.ganhou !== 1'b1) begin
                                n_bad++; $display("FAIL rand_win: got %h expected %h", bus.db_estado, S_GANHOU);
                            end
                            over = 1'b1;
                        end else begin
                            if (bus.db_estado !== S_PROXIMA_RODADA) begin
                                n_bad++; $display("FAIL rand_next_round: got %h expected %h", bus.db_estado, S_PROXIMA_RODADA);
                            end
                            rnd++;
                            need_show = 1'b1;
                        end
                        break;
                    end else begin
                        n_cmp++;
                        if (bus.db_estado !== S_PROXIMA_NOTA) begin
                            n_bad++; $display("FAIL rand_next_note: got %h expected %h", bus.db_estado, S_PROXIMA_NOTA);
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        bus.iniciar = 1'b0;
        bus.fimTempo = 1'b0;
        bus.nota_feita = 1'b0;
        bus.nota_correta = 1'b0;
        bus.tempo_correto = 1'b0;
        bus.tentar_dnv = 1'b0;
        bus.tentar_dnv_rep = 1'b0;
        bus.modo = 2'd0;
        test_reset();
        auto_dp = 1'b1;
        test_progressive_win();
        test_full_song();
        test_wrong_note();
        test_timeouts();
        test_free_play();
        test_output_decode();
        test_async_reset();
        test_random_games();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/modo_jogo_controle.md
MODO_JOGO_CONTROLE -- requirements
Module: modo_jogo_controle

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, width of note address and round counters.
REQ-002 SHALL have parameter ULTIMA, default 15, last valid note address; legal range 0..2^ADDR_W-1.
REQ-003 SHALL have parameter VIDAS, default 3, lives per game; legal range 1..7; lives counter is 3 bits.
REQ-004 SHALL have ports clock in 1 (system clock, rising edge) and reset in 1 (asynchronous, active-low).
REQ-005 SHALL have inputs iniciar, fimTF, fimTempo, tempo_mostra_ok, nota_feita, nota_correta, tempo_correto, tentar_dnv, tentar_dnv_rep, each 1 bit.
REQ-006 SHALL have input modo, 2 bits: 0 progressive, 1 full song, 2 free play, 3 treated as 0.
REQ-007 SHALL have outputs endereco [ADDR_W-1:0] (note memory address) and rodada [ADDR_W-1:0] (current last note of the round).
REQ-008 SHALL have output vidas [2:0], the remaining lives.
REQ-009 SHALL have 1-bit outputs zeraTF, contaTF, zeraTempo, contaTempo, zeraMetro, contaMetro, zeraR, registraR, toca, ativa_leds, leds_mem, vez_jogador, ganhou, perdeu.
REQ-010 SHALL have output db_estado [4:0], equal to the current state code.

Function
REQ-011 SHALL be a Moore FSM; all 1-bit control outputs are decoded from the current state only.
REQ-012 SHALL use states and codes: INICIAL 0x00, INICIALIZA 0x01, INICIO_RODADA 0x02, MOSTRA 0x03, ESPERA_MOSTRA 0x04, APAGA_MOSTRA 0x05, INICIO_NOTA 0x06, ESPERA_NOTA 0x07, TOCA_NOTA 0x08, COMPARA 0x09, PROXIMA_NOTA 0x0A, PROXIMA_RODADA 0x0B, ERROU 0x0C, AGUARDA 0x0D, GANHOU 0x0E, DERROTA 0x0F; any other code goes to INICIAL.
REQ-013 SHALL transition INICIAL->INICIALIZA on iniciar; in INICIALIZA, latch modo into modo_reg, set endereco=0, set vidas=VIDAS, set rodada=ULTIMA if modo_reg=1, else 0.
REQ-014 SHALL transition INICIALIZA->INICIO_NOTA if modo_reg=2, else ->INICIO_RODADA.
REQ-015 SHALL transition INICIO_RODADA->MOSTRA on fimTF, with endereco cleared to 0 in INICIO_RODADA.
REQ-016 SHALL transition MOSTRA->ESPERA_MOSTRA unconditionally.
REQ-017 SHALL, in ESPERA_MOSTRA on tempo_mostra_ok, go to INICIO_NOTA if endereco==rodada, else to APAGA_MOSTRA.
REQ-018 SHALL, in APAGA_MOSTRA on fimTF, increment endereco and go to MOSTRA.
REQ-019 SHALL, in INICIO_NOTA, clear endereco to 0 and go to ESPERA_NOTA.
REQ-020 SHALL, in ESPERA_NOTA, go to ERROU on fimTemo when modo_reg!=2, else to TOCA_NOTA on nota_feita; fimTempo has priority; in modo_reg=2 fimTempo is ignored and iniciar goes to INICIALIZA.
REQ-021 SHALL hold TOCA_NOTA while nota_feita=1, then go to ESPERA_NOTA if modo_reg=2, else to COMPARA.
REQ-022 SHALL, in COMPARA, go to ERROU if !nota_correta or !tempo_correto; else to GANHOU if endereco==rodada and rodada==ULTIMA; else to PROXIMA_RODADA if endereco==rodada; else to PROXIMA_NOTA.
REQ-023 SHALL, in PROXIMA_NOTA, increment endereco and go to ESPERA_NOTA.
REQ-024 SHALL, in PROXIMA_RODADA, increment rodada and go to INICIO_RODADA.
REQ-025 SHALL, in ERROU, decrement vidas (saturating at 0) and go to DERROTA if vidas==1 on entry, else to AGUARDA.
REQ-026 SHALL, in AGUARDA, go to INICIO_RODADA on tentar_dnv_rep, else to INICIO_NOTA on tentar_dnv; tentar_dnv_rep has priority.
REQ-027 SHALL hold GANHOU and DERROTA until iniciar, then go to INICIALIZA.
REQ-028 SHALL decode outputs as follows: zeraR in INICIAL; zeraTF in INICIALIZA, MOSTRA, INICIO_NOTA; contaTF in INICIO_RODADA, APAGA_MOSTRA; zeraTempo in INICIALIZA, INICIO_NOTA, PROXIMA_NOTA, ERROU; contaTempo and vez_jogador in ESPERA_NOTA; registraR in TOCA_NOTA; zeraMetro in INICIALIZA, MOSTRA, INICIO_NOTA, PROXIMA_NOTA, ERROU; contaMetro, toca, ativa_leds in ESPERA_MOSTRA, TOCA_NOTA; leds_mem in ESPERA_MOSTRA; ganhou in GANHOU; perdeu in AGUARDA, DERROTA.
REQ-029 SHALL keep endereco and rodada within 0..ULTIMA and never wrap, because COMPARA exits the round before any increment past rodada.

Reset
REQ-030 SHALL, while reset=0, asynchronously force state INICIAL, endereco=0, rodada=0, vidas=VIDAS, and modo_reg=0; all 1-bit outputs are then 0 except zeraR=1.
REQ-031 SHALL abort any game on reset assertion mid-operation, with no partial counter updates retained.

Verification
REQ-032 SHALL pass this check: progressive mode, ULTIMA=2, all notes correct -> rounds show 1, 2, 3 notes; GANHOU is reached with endereco=rodada=2 and ganhou=1.
REQ-033 SHALL pass this check: full-song mode (modo=1) -> rodada=ULTIMA right after INICIALIZA; all ULTIMA+1 notes are shown before the first vez_jogador.
REQ-034 SHALL pass this check: wrong note at endereco=1 with VIDAS=3 -> vidas=2, state AGUARDA; tentar_dnv -> INICIO_NOTA with endereco=0.
REQ-035 SHALL pass this check: three fimTempo timeouts with VIDAS=3 -> vidas 2, 1, 0; the third goes to DERROTA; perdeu=1 until iniciar.
REQ-036 SHALL pass this check: free play (modo=2) -> fimTempo is ignored, and each nota_feita pulse gives registraR high for its duration; iniciar -> INICIALIZA.
REQ-037 SHALL pass this check: reset low during ESPERA_MOSTRA -> db_estado=0x00 without waiting for a clock edge, with vidas=VIDAS.
